seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment display controller; next generation of the fixed 4-digit hex display driver.
- Drives DIGITS common-anode digits from a packed hex value.
- Adds per-digit decimal point, per-digit blanking, PWM brightness, and a double-buffered load handshake. Updates commit only at frame boundaries, so the display never shows a torn value.
- Sits between any register/debug source and the board seg/an pins.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- DIV_W, 17, log2 of clocks per digit slot; must satisfy DIV_W >= BRIGHT_W+1.
- BRIGHT_W, 4, width of the brightness code.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  4*DIGITS  hex value; nibble i (value[4i+3:4i]) shows on digit i; digit 0 is rightmost
- dp  in  DIGITS  decimal point per digit, 1=lit
- blank  in  DIGITS  per-digit blank, 1=digit dark (dp also dark)
- bright  in  BRIGHT_W  brightness code, 0=off, all-ones=full
- load  in  1  request to capture value/dp/blank/bright
- ready  out  1  load is accepted this cycle when high
- frame_start  out  1  one-cycle pulse when digit 0 slot begins
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- an  out  DIGITS  active-low anode enables

Behaviour:
- Reset is asynchronous, active-low; clk and rst_n are the block's only clock and reset.
- Reset values:
  - seg = all ones, an = all ones, ready = 1, frame_start = 0.
  - Prescaler, digit index, pending registers and display registers = 0.
  - Display blank mask = all ones (dark).
- Prescaler:
  - DIV_W-bit free-running counter.
  - Digit index increments when the prescaler wraps; index wraps DIGITS-1 -> 0. Non-power-of-two DIGITS is wrapped explicitly.
- Frame boundary: the cycle where the prescaler wraps and the index goes DIGITS-1 -> 0.
  - frame_start is registered and pulses in the cycle after the boundary.
- Load handshake:
  - load && ready captures value, dp, blank and bright into pending registers; ready goes 0 next cycle.
  - load while ready=0 is ignored, with no effect on pending registers.
  - At the next frame boundary, pending registers copy into display registers; ready returns to 1 the following cycle.
  - A capture in the same cycle as a boundary commits at the following boundary, not the current one.
- Segment decode (active low, seg[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - seg[7] = ~dp[idx].
  - A blanked digit drives seg = 8'hFF.
- Brightness:
  - sub = prescaler[DIV_W-1 -: BRIGHT_W].
  - Anode active when sub < bright, or when bright is all ones (full duty).
  - an[idx] = 0 only when the anode is active and the digit is not blanked; all other an bits are 1.
  - When the anode is inactive, seg = 8'hFF.
- Latency: seg and an are registered; each is one clock behind the prescaler/index state.
- Exactly one an bit is low at any time, or none.

Optional Feature:
- Macro: SEG7_SCAN_LZS_EN.
- Defined: leading-zero suppression.
  - Every digit above the most significant nonzero nibble of the display value is forced blank (seg=8'hFF, an high).
  - Digit 0 is always shown unless blank[0] is set.
  - The suppression mask is computed from the display registers, not the pending registers.
- Undefined: zeros display normally; no extra logic.

Test Plan:
Bench configuration: DIGITS=4, DIV_W=4, BRIGHT_W=2.
- Reset, then release with no load -> seg=FF and an=F for 3 frames; ready=1.
- Load value=16'h12AF, dp=0, blank=0, bright=3 -> ready low until the first boundary, then high. Each 16-clock slot shows an=E/seg=8E, an=D/seg=88, an=B/seg=A4, an=7/seg=F9, with frame_start pulsing once per 64 clocks.
- bright=2 -> each digit's an bit is low 8 of 16 clocks; bright=0 -> an stays F throughout.
- dp=4'b0100, blank=4'b0001 -> digit 2 seg[7]=0; digit 0 slot has an=F and seg=FF.
- Load pulse asserted while ready=0 with value=16'hFFFF -> ignored; the first pending value is displayed. Load on the boundary cycle -> commits one frame later.
- With SEG7_SCAN_LZS_EN: value=16'h0030 -> digits 3 and 2 dark, digit 1 shows 3, digit 0 shows 0. Without the macro: all four digits lit.
- Assert rst_n low mid-frame -> seg=FF, an=F, and ready=1 immediately (asynchronous), with the pending load discarded.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: double-buffered load, per-digit dp/blank, PWM brightness.
// Leading-zero suppression is added when SEG7_SCAN_LZS_EN is defined.
module seg7_scan_ctrl #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned DIV_W    = 17,
   parameter int unsigned BRIGHT_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic [BRIGHT_W-1:0]   bright,
   input  logic                  load,
   output logic                  ready,
   output logic                  frame_start,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an
);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned VAL_W = 4 * DIGITS;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   typedef enum logic [0:0] {ST_IDLE, ST_PEND} state_e;

   state_e              state_q, state_d;
   logic                ready_q, ready_d;
   logic                fs_q, fs_d;
   logic [DIV_W-1:0]    presc_q, presc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [VAL_W-1:0]    pend_value_q, pend_value_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic [BRIGHT_W-1:0] pend_bright_q, pend_bright_d;
   logic [VAL_W-1:0]    disp_value_q, disp_value_d;
   logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
   logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;
   logic [BRIGHT_W-1:0] disp_bright_q, disp_bright_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic                wrap;
   logic                boundary;
   logic [DIGITS-1:0]   lz_mask;
   logic [DIGITS-1:0]   eff_blank;
   logic [3:0]          nib;
   logic                cur_dp;
   logic                cur_blank;
   logic [BRIGHT_W-1:0] sub;
   logic                anode_on;
   logic                lit;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0:    return 7'b1000000;
         4'h1:    return 7'b1111001;
         4'h2:    return 7'b0100100;
         4'h3:    return 7'b0110000;
         4'h4:    return 7'b0011001;
         4'h5:    return 7'b0010010;
         4'h6:    return 7'b0000010;
         4'h7:    return 7'b1111000;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0010000;
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b0000011;
         4'hC:    return 7'b1000110;
         4'hD:    return 7'b0100001;
         4'hE:    return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   assign wrap     = &presc_q;
   assign boundary = wrap && (idx_q == IDX_LAST);

   // Scan timebase; explicit index wrap covers non-power-of-two DIGITS.
   always_comb begin
      presc_d = presc_q + DIV_W'(1);
      idx_d   = idx_q;
      if (wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      fs_d = boundary;
   end

   // Load handshake: PEND holds a captured payload until the next frame boundary.
   always_comb begin
      state_d       = state_q;
      pend_value_d  = pend_value_q;
      pend_dp_d     = pend_dp_q;
      pend_blank_d  = pend_blank_q;
      pend_bright_d = pend_bright_q;
      disp_value_d  = disp_value_q;
      disp_dp_d     = disp_dp_q;
      disp_blank_d  = disp_blank_q;
      disp_bright_d = disp_bright_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               pend_value_d  = value;
               pend_dp_d     = dp;
               pend_blank_d  = blank;
               pend_bright_d = bright;
               state_d       = ST_PEND;
            end
         end
         ST_PEND: begin
            if (boundary) begin
               disp_value_d  = pend_value_q;
               disp_dp_d     = pend_dp_q;
               disp_blank_d  = pend_blank_q;
               disp_bright_d = pend_bright_q;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

`ifdef SEG7_SCAN_LZS_EN
   logic upper_zero;

   // A digit is suppressed when it and every digit above it hold zero; digit 0 never is.
   always_comb begin
      lz_mask    = '0;
      upper_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         upper_zero = upper_zero && (disp_value_q[4*i +: 4] == 4'h0);
         lz_mask[i] = upper_zero;
      end
   end
`else
   assign lz_mask = '0;
`endif

   assign eff_blank = disp_blank_q | lz_mask;

   // Segment/anode drive for the digit currently in its slot.
   always_comb begin
      nib       = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib       = disp_value_q[4*i +: 4];
            cur_dp    = disp_dp_q[i];
            cur_blank = eff_blank[i];
         end
      end
      sub      = presc_q[DIV_W-1 -: BRIGHT_W];
      anode_on = (sub < disp_bright_q) || (&disp_bright_q);
      lit      = anode_on && !cur_blank;
      seg_d    = lit ? {~cur_dp, hex_to_seg(nib)} : 8'hFF;
      an_d     = '1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         an_d[i] = ~(lit && (idx_q == IDX_W'(i)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ready_q       <= 1'b1;
         fs_q          <= 1'b0;
         presc_q       <= '0;
         idx_q         <= '0;
         pend_value_q  <= '0;
         pend_dp_q     <= '0;
         pend_blank_q  <= '0;
         pend_bright_q <= '0;
         disp_value_q  <= '0;
         disp_dp_q     <= '0;
         disp_blank_q  <= '1;
         disp_bright_q <= '0;
         seg_q         <= 8'hFF;
         an_q          <= '1;
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         fs_q          <= fs_d;
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         pend_value_q  <= pend_value_d;
         pend_dp_q     <= pend_dp_d;
         pend_blank_q  <= pend_blank_d;
         pend_bright_q <= pend_bright_d;
         disp_value_q  <= disp_value_d;
         disp_dp_q     <= disp_dp_d;
         disp_blank_q  <= disp_blank_d;
         disp_bright_q <= disp_bright_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
      end
   end

   assign ready       = ready_q;
   assign frame_start = fs_q;
   assign seg         = seg_q;
   assign an          = an_q;

endmodule
